snake_body_ctrl: RTL and testbench

SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

---
 rtl/snake_body_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_ctrl.sv
// Segment-RAM sequencer for the snake body: power-up clear/init, per-move tail erase,
// body shift, head write and per-segment pixel streaming to the VGA writer.
module snake_body_ctrl #(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned MAX_LEN     = 2000,
   parameter int unsigned INIT_LEN    = 3,
   parameter int unsigned GROW_STEP   = 5,
   parameter int unsigned CELL_PIX    = 16,
   parameter logic [2:0]  HEAD_COLOUR = 3'b100
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go,
   input  logic                        grow,
   input  logic                        is_dead,
   input  logic [2:0]                  colour_in,
   output logic [ADDR_W-1:0]           addr,
   output logic                        clr_we,
   output logic                        init_we,
   output logic                        shift_we,
   output logic                        head_we,
   output logic                        draw_en,
   output logic [$clog2(CELL_PIX)-1:0] pix_idx,
   output logic [2:0]                  colour_out,
   output logic [ADDR_W-1:0]           len,
   output logic                        full,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int unsigned       PIX_W    = $clog2(CELL_PIX);
   localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(CELL_PIX - 1);
   localparam logic [PIX_W-1:0]  PIX_ONE  = PIX_W'(1);
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MAX_LEN - 1);
   localparam logic [ADDR_W-1:0] LEN_INIT = ADDR_W'(INIT_LEN);
   localparam logic [ADDR_W-1:0] LEN_MAX  = ADDR_W'(MAX_LEN);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   // One spare bit so MAX_LEN == 2**ADDR_W and len+GROW_STEP compare without wrap.
   localparam logic [ADDR_W:0]   MAX_EXT  = (ADDR_W + 1)'(MAX_LEN);
   localparam logic [ADDR_W:0]   STEP_EXT = (ADDR_W + 1)'(GROW_STEP);

   typedef enum logic [3:0] {
      StClear, StInit, StIdle, StErase, StShiftRd, StShiftWr, StHeadWr, StDraw, StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic                pend_q, pend_d;
   logic [ADDR_W-1:0]   len_last;
   logic [ADDR_W:0]     grown;

   assign len_last = len_q - ONE;
   assign grown    = {1'b0, len_q} + STEP_EXT;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StClear;
         cnt_q   <= '0;
         pix_q   <= '0;
         len_q   <= LEN_INIT;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pix_q   <= pix_d;
         len_q   <= len_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pix_d   = pix_q;
      len_d   = len_q;
      pend_d  = pend_q | grow;
      unique case (state_q)
         StClear: begin
            if (cnt_q == CLR_LAST) begin
               state_d = StInit;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         StInit: begin
            if (cnt_q == len_last) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         StIdle: begin
            if (go) begin
               state_d = StErase;
               pix_d   = '0;
            end
         end
         StErase: begin
            pix_d = pix_q + PIX_ONE;
            if (pix_q == PIX_LAST) begin
               state_d = StShiftRd;
               cnt_d   = len_last;
            end
         end
         StShiftRd: state_d = StShiftWr;
         StShiftWr: begin
            cnt_d   = cnt_q - ONE;
            state_d = (cnt_q == ONE) ? StHeadWr : StShiftRd;
         end
         StHeadWr: begin
            // A grow arriving in this very cycle is kept for the next move.
            if (pend_q) begin
               len_d  = (grown > MAX_EXT) ? LEN_MAX : grown[ADDR_W-1:0];
               pend_d = grow;
            end
            cnt_d   = '0;
            pix_d   = '0;
            state_d = StDraw;
         end
         StDraw: begin
            pix_d = pix_q + PIX_ONE;
            if (pix_q == PIX_LAST) begin
               if (cnt_q == len_last) begin
                  state_d = StDone;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StClear;
      endcase
      if (is_dead) begin
         state_d = StClear;
         cnt_d   = '0;
         pix_d   = '0;
         len_d   = LEN_INIT;
         pend_d  = 1'b0;
      end
   end

   always_comb begin
      addr       = cnt_q;
      clr_we     = 1'b0;
      init_we    = 1'b0;
      shift_we   = 1'b0;
      head_we    = 1'b0;
      draw_en    = 1'b0;
      colour_out = 3'b000;
      frame_done = 1'b0;
      unique case (state_q)
         StClear:   clr_we = 1'b1;
         StInit:    init_we = 1'b1;
         StIdle:    ;
         StErase: begin
            addr    = len_last;
            draw_en = 1'b1;
         end
         StShiftRd: addr = cnt_q - ONE;
         StShiftWr: shift_we = 1'b1;
         StHeadWr: begin
            addr    = '0;
            head_we = 1'b1;
         end
         StDraw: begin
            draw_en    = 1'b1;
            colour_out = (cnt_q == '0) ? HEAD_COLOUR : colour_in;
         end
         StDone:    frame_done = 1'b1;
         default:   ;
      endcase
      // State sits at CLEAR during reset; keep the RAM and VGA side quiet until release.
      if (!rst) begin
         clr_we     = 1'b0;
         init_we    = 1'b0;
         shift_we   = 1'b0;
         head_we    = 1'b0;
         draw_en    = 1'b0;
         colour_out = 3'b000;
         frame_done = 1'b0;
      end
   end

   assign pix_idx = pix_q;
   assign len     = len_q;
   assign full    = ({1'b0, len_q} == MAX_EXT);
   assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: scoreboarded strobe/pixel stream on a default instance,
// plus length, saturation and mid-move reset checks on a MAX_LEN=10 instance.
module tb_snake_body_ctrl;

   localparam int unsigned AW   = 11;
   localparam logic [2:0]  BODY = 3'b011;
   localparam logic [2:0]  HEAD = 3'b100;
   localparam logic [5:0]  K_CLR   = 6'b100000;
   localparam logic [5:0]  K_INIT  = 6'b010000;
   localparam logic [5:0]  K_SHIFT = 6'b001000;
   localparam logic [5:0]  K_HEAD  = 6'b000100;
   localparam logic [5:0]  K_DRAW  = 6'b000010;
   localparam logic [5:0]  K_DONE  = 6'b000001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, go, grow, is_dead;
   logic [2:0]    colour_in, colour_out;
   logic [AW-1:0] addr, len;
   logic          clr_we, init_we, shift_we, head_we, draw_en, full, busy, frame_done;
   logic [3:0]    pix_idx;

   snake_body_ctrl dut (
      .clk(clk), .rst(rst), .go(go), .grow(grow), .is_dead(is_dead), .colour_in(colour_in),
      .addr(addr), .clr_we(clr_we), .init_we(init_we), .shift_we(shift_we), .head_we(head_we),
      .draw_en(draw_en), .pix_idx(pix_idx), .colour_out(colour_out), .len(len), .full(full),
      .busy(busy), .frame_done(frame_done)
   );

   logic          s_rst, s_go, s_grow, s_dead;
   logic [2:0]    s_cin, s_col;
   logic [AW-1:0] s_addr, s_len;
   logic          s_clr, s_init, s_shift, s_head, s_draw, s_full, s_busy, s_done;
   logic [1:0]    s_pix;

   snake_body_ctrl #(
      .ADDR_W(AW), .MAX_LEN(10), .INIT_LEN(3), .GROW_STEP(5), .CELL_PIX(4), .HEAD_COLOUR(HEAD)
   ) sdut (
      .clk(clk), .rst(s_rst), .go(s_go), .grow(s_grow), .is_dead(s_dead), .colour_in(s_cin),
      .addr(s_addr), .clr_we(s_clr), .init_we(s_init), .shift_we(s_shift), .head_we(s_head),
      .draw_en(s_draw), .pix_idx(s_pix), .colour_out(s_col), .len(s_len), .full(s_full),
      .busy(s_busy), .frame_done(s_done)
   );

   typedef struct packed {
      logic [5:0]    kind;
      logic [AW-1:0] addr;
      logic [3:0]    pix;
      logic [2:0]    col;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   s_done_cnt = 0;

   function automatic void push(input logic [5:0] k, input int a, input int p, input logic [2:0] c);
      obs_t o;
      o.kind = k;
      o.addr = AW'(a);
      o.pix  = 4'(p);
      o.col  = c;
      exp_q.push_back(o);
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: every cycle the DUT shows a strobe/pixel/done, pop and compare.
   always @(negedge clk) begin
      obs_t act;
      obs_t e;
      act.kind = {clr_we, init_we, shift_we, head_we, draw_en, frame_done};
      act.addr = addr;
      act.pix  = pix_idx;
      act.col  = colour_out;
      if (act.kind != 6'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%b addr=%0d, required no output",
                     act.kind, act.addr);
         end else begin
            e = exp_q.pop_front();
            if (act.kind != e.kind || (e.kind != K_DONE && act.addr != e.addr) ||
                (e.kind == K_DRAW && act.pix != e.pix) || act.col != e.col) begin
               errors++;
               $display("FAIL sb_stream: got kind=%b addr=%0d pix=%0d col=%b, required kind=%b addr=%0d pix=%0d col=%b",
                        act.kind, act.addr, act.pix, act.col, e.kind, e.addr, e.pix, e.col);
            end
         end
      end
      if (s_done) s_done_cnt++;
   end

   task automatic push_boot();
      for (int a = 0; a < 2000; a++) push(K_CLR, a, 0, 3'b000);
      for (int a = 0; a < 3; a++) push(K_INIT, a, 0, 3'b000);
   endtask

   task automatic push_erase(input int l0);
      for (int p = 0; p < 16; p++) push(K_DRAW, l0 - 1, p, 3'b000);
   endtask

   // l0: length at go, l1: length after the head write.
   task automatic push_move(input int l0, input int l1);
      push_erase(l0);
      for (int i = l0 - 1; i >= 1; i--) push(K_SHIFT, i, 0, 3'b000);
      push(K_HEAD, 0, 0, 3'b000);
      for (int k = 0; k < l1; k++)
         for (int p = 0; p < 16; p++) push(K_DRAW, k, p, (k == 0) ? HEAD : BODY);
      push(K_DONE, 0, 0, 3'b000);
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while (busy !== 1'b0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(busy === 1'b0), 1);
   endtask

   // n counts negedges after the edge that samples go; inputs are set per-n.
   task automatic run_move(input string name, input int exp_cyc, input int grow_at,
                           input int go_from, input int go_to, input int dead_at);
      int n = 0;
      bit seen = 1'b0;
      @(posedge clk);
      #1 go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         if (frame_done) seen = 1'b1;
         grow    = (n == grow_at);
         go      = (n >= go_from && n <= go_to);
         is_dead = (n == dead_at);
      end
      grow    = 1'b0;
      go      = 1'b0;
      is_dead = 1'b0;
      if (exp_cyc > 0) check(name, seen ? n : -1, exp_cyc);
      else check(name, int'(seen), 0);
   endtask

   task automatic s_pulse_grow();
      @(posedge clk);
      #1 s_grow = 1'b1;
      @(posedge clk);
      #1 s_grow = 1'b0;
   endtask

   task automatic s_move(input string name);
      int n = 0;
      @(posedge clk);
      #1 s_go = 1'b1;
      @(posedge clk);
      #1 s_go = 1'b0;
      while (!s_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(s_done), 1);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; go = 1'b0; grow = 1'b0; is_dead = 1'b0; colour_in = BODY;
      s_rst = 1'b0; s_go = 1'b0; s_grow = 1'b0; s_dead = 1'b0; s_cin = 3'b010;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 1);
      check("rst_len", int'(len), 3);
      check("rst_full", int'(full), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_strobes", int'({clr_we, init_we, shift_we, head_we, draw_en, frame_done}), 0);
      check("rst_colour", int'(colour_out), 0);

      // Boot: 2000 clears then 3 inits
      push_boot();
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      wait_idle("boot_idle", 2100);
      check("boot_len", int'(len), 3);
      check("boot_queue_empty", exp_q.size(), 0);

      // Move 1: grow and a held go both land in DRAW
      push_move(3, 3);
      run_move("move1_latency", 70, 40, 30, 60, 0);
      check("move1_len", int'(len), 3);
      repeat (5) @(negedge clk);
      check("move1_idle", int'(busy), 0);
      check("move1_queue_empty", exp_q.size(), 0);

      // Move 2: pending grow applied at head write
      push_move(3, 8);
      run_move("move2_latency", 150, 0, 0, -1, 0);
      check("move2_len", int'(len), 8);
      check("move2_full", int'(full), 0);

      // Move 3: death in SHIFT_WR with simultaneous grow
      push_erase(8);
      push(K_SHIFT, 7, 0, 3'b000);
      push_boot();
      run_move("dead_no_done", 0, 18, 0, -1, 18);
      check("dead_len", int'(len), 3);
      check("dead_busy", int'(busy), 1);
      wait_idle("dead_idle", 2200);
      check("dead_len_idle", int'(len), 3);

      // Move 4: no stale grow survives the death
      push_move(3, 3);
      run_move("move4_latency", 70, 0, 0, -1, 0);
      check("move4_len", int'(len), 3);

      // Small instance: saturation at MAX_LEN=10
      repeat (2) @(negedge clk);
      check("s_rst_busy", int'(s_busy), 1);
      check("s_rst_full", int'(s_full), 0);
      @(posedge clk);
      #1 s_rst = 1'b1;
      repeat (20) @(negedge clk);
      check("s_boot_idle", int'(s_busy), 0);
      check("s_boot_len", int'(s_len), 3);
      s_pulse_grow();
      s_move("s_move_a");
      check("s_len_8", int'(s_len), 8);
      check("s_full_8", int'(s_full), 0);
      s_pulse_grow();
      s_move("s_move_b");
      check("s_len_sat", int'(s_len), 10);
      check("s_full_sat", int'(s_full), 1);
      s_pulse_grow();
      s_move("s_move_c");
      check("s_len_hold", int'(s_len), 10);
      check("s_full_hold", int'(s_full), 1);

      // Reset mid-move abandons it without frame_done
      begin
         int done_before;
         done_before = s_done_cnt;
         @(posedge clk);
         #1 s_go = 1'b1;
         @(posedge clk);
         #1 s_go = 1'b0;
         repeat (6) @(posedge clk);
         #1 s_rst = 1'b0;
         @(negedge clk);
         check("s_mid_rst_len", int'(s_len), 3);
         check("s_mid_rst_full", int'(s_full), 0);
         check("s_mid_rst_draw", int'(s_draw), 0);
         check("s_mid_rst_busy", int'(s_busy), 1);
         check("s_mid_rst_col", int'(s_col), 0);
         @(posedge clk);
         #1 s_rst = 1'b1;
         repeat (20) @(negedge clk);
         check("s_mid_rst_idle", int'(s_busy), 0);
         check("s_mid_rst_no_done", s_done_cnt - done_before, 0);
      end

      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
